pid_secuenciador: RTL and testbench
===================================

Name: pid_secuenciador

Overview:
Sample-rate controller for the servomotor PID loop. It generates the sample tick and maintains the error history: the previous sample for the D term and a saturating integral for the I term. One shared fixed-point multiplier (Multiplicacion instance outside this block) is time-multiplexed over the P, I and D gains. Each sample period it emits one saturated control word `u` with a single-cycle valid strobe.

Parameters:
- Magnitud, 17, integer bits of the signed fixed-point format.
- Decimal, 0, fractional bits of the fixed-point format.
- N, Magnitud+Decimal+1, total signed word width (18 by default).
- DIV_MUESTREO, 50000, clk cycles per sample period; legal range is 6 or more.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- habilitar  in  1  run enable for the sample counter.
- error  in  N  signed error sample (setpoint minus position).
- kp  in  N  signed proportional gain, fixed-point.
- ki  in  N  signed integral gain.
- kd  in  N  signed derivative gain.
- mult_a  out  N  operand A to the shared multiplier (gain).
- mult_b  out  N  operand B to the shared multiplier (term).
- mult_p  in  N  product back from the multiplier; combinational, already saturated and rescaled to N bits.
- u  out  N  signed control output, registered.
- u_valido  out  1  one-cycle strobe marking a new `u`.
- ocupado  out  1  high while a sequence is in progress (state is not IDLE).

Behaviour:
- Reset (asynchronous): all registers go to 0. This covers cnt, e_k, e_prev, diff, integ, p_reg, i_reg, d_reg and u. u_valido=0, ocupado=0, state=IDLE.
- Sample counter:
  - cnt runs 0..DIV_MUESTREO-1 and wraps while habilitar=1.
  - habilitar=0 clears cnt to 0 on the next edge.
  - tick = habilitar & (cnt==DIV_MUESTREO-1), combinational.
- Saturation helper sat(x): clamp to [-2^(N-1), 2^(N-1)-1]. Every add or subtract is computed at N+2 bits, then saturated.
- FSM states: IDLE, MUL_P, MUL_I, MUL_D, SUMA.
  - IDLE, on tick: e_k<=error; diff<=sat(error - e_prev); integ<=sat(integ + error); go to MUL_P.
  - MUL_P: mult_a=kp, mult_b=e_k; p_reg<=mult_p; go to MUL_I.
  - MUL_I: mult_a=ki, mult_b=integ; i_reg<=mult_p; go to MUL_D.
  - MUL_D: mult_a=kd, mult_b=diff; d_reg<=mult_p; go to SUMA.
  - SUMA: u<=sat(p_reg + i_reg + d_reg); u_valido<=1; e_prev<=e_k; go to IDLE.
- mult_a and mult_b are 0 whenever state is IDLE or SUMA.
- Latency: if the tick is sampled at edge E0, `u` and u_valido=1 appear after edge E4 and u_valido is high for exactly one cycle.
- ocupado is high from after E0 until after E4.
- u holds its value between strobes.
- error, kp, ki and kd are sampled only in the states listed above. Changes at other times have no effect on the sequence in progress.
- habilitar=0 mid-sequence: the current sequence still completes and delivers `u`. No new tick occurs while habilitar is low. integ and e_prev are retained, not cleared.
- First sample after reset: e_prev=0, so diff equals error.
- Integral clamp: integ sticks at +max or -min and recovers as soon as an error of opposite sign arrives (no wind-up beyond the clamp).
- Since DIV_MUESTREO is 6 or more, a tick can never arrive outside IDLE. There is no overrun path.
- Reset asserted mid-sequence aborts immediately: no u_valido is emitted, and all history is lost.

Test Plan:
1. DIV_MUESTREO=8, kp=2, ki=0, kd=0, error=100, habilitar=1 → u=200, u_valido pulses once every 8 cycles, 4 edges after each tick.
2. ki=1, kp=kd=0, error=5 held over 3 samples → u=5, 10, 15. Then error=-5 for one sample → u=10.
3. kd=1, kp=ki=0, error=10 then 30 then 30 → u=10, 20, 0.
4. Saturation, kp=1, ki=1, kd=0, error=131071:
   - 2 samples → u=131071 both times, and integ clamps at 131071.
   - Then error=-131072 → integ=-1, u=-131072 (saturated negative).
5. Check mult_a/mult_b against the FSM: bench multiplier model mult_p=sat(mult_a*mult_b). mult_a/mult_b must equal kp/e_k, ki/integ, kd/diff in consecutive cycles, and 0 otherwise.
6. Abort and run-enable:
   - reset pulsed during MUL_I → u=0, no strobe, ocupado=0.
   - Next sample with kd=1, error=7 → u=7, since e_prev was cleared.
   - habilitar dropped in MUL_P → that sequence still strobes, and no further strobes follow.

Source files
------------

// File: rtl/pid_secuenciador_if.sv
// Bus to the shared fixed-point multiplier: gain and term out, product back.
interface pid_secuenciador_if #(
  parameter int N = 18
) ();
  logic signed [N-1:0] mult_a;
  logic signed [N-1:0] mult_b;
  logic signed [N-1:0] mult_p;

  // Sequencer side: drives the operands, reads the product.
  modport master (
    output mult_a,
    output mult_b,
    input  mult_p
  );

  // Multiplier side: reads the operands, returns the product.
  modport slave (
    input  mult_a,
    input  mult_b,
    output mult_p
  );
endinterface

// File: rtl/pid_secuenciador.sv
// PID sample-rate sequencer: generates the sample tick, keeps the error
// history (previous sample, saturating integral) and time-multiplexes one
// external multiplier over the P, I and D gains to produce a saturated u.
module pid_secuenciador #(
  parameter int Magnitud     = 17,
  parameter int Decimal      = 0,
  parameter int N            = Magnitud + Decimal + 1,
  parameter int DIV_MUESTREO = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                habilitar,
  input  logic signed [N-1:0] error,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  input  logic signed [N-1:0] kd,
  pid_secuenciador_if.master  mbus,
  output logic signed [N-1:0] u,
  output logic                u_valido,
  output logic                ocupado
);

  localparam int              CW      = $clog2(DIV_MUESTREO);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV_MUESTREO - 1);
  localparam logic signed [N+1:0] SMAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SMIN = {3'b111, {(N-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SUMA} estado_t;

  estado_t             state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tick;
  logic signed [N-1:0] e_k_q, e_prev_q, diff_q, integ_q;
  logic signed [N-1:0] p_q, i_q, d_q, u_q;
  logic                u_valido_q, ocupado_q;

  // Sign-extend an N-bit word to the N+2-bit arithmetic width.
  function automatic logic signed [N+1:0] ext(input logic signed [N-1:0] x);
    return {{2{x[N-1]}}, x};
  endfunction

  // Clamp an N+2-bit intermediate into the signed N-bit range.
  function automatic logic signed [N-1:0] sat(input logic signed [N+1:0] x);
    logic signed [N+1:0] r;
    if (x > SMAX)      r = SMAX;
    else if (x < SMIN) r = SMIN;
    else               r = x;
    return r[N-1:0];
  endfunction

  assign tick = habilitar && (cnt_q == CNT_MAX);

  // Next sample-counter value: wraps at the period, clears when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!habilitar)            cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = '0;
    else                       cnt_d = cnt_q + CW'(1);
  end

  // Sample counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Multiplier operand mux: one gain/term pair per multiply state, else zero.
  always_comb begin
    mbus.mult_a = '0;
    mbus.mult_b = '0;
    case (state_q)
      MUL_P: begin mbus.mult_a = kp; mbus.mult_b = e_k_q;   end
      MUL_I: begin mbus.mult_a = ki; mbus.mult_b = integ_q; end
      MUL_D: begin mbus.mult_a = kd; mbus.mult_b = diff_q;  end
      default: ;
    endcase
  end

  // Sequencer FSM: capture history on tick, three multiplies, final sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      e_k_q      <= '0;
      e_prev_q   <= '0;
      diff_q     <= '0;
      integ_q    <= '0;
      p_q        <= '0;
      i_q        <= '0;
      d_q        <= '0;
      u_q        <= '0;
      u_valido_q <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      u_valido_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            e_k_q     <= error;
            diff_q    <= sat(ext(error) - ext(e_prev_q));
            integ_q   <= sat(ext(integ_q) + ext(error));
            ocupado_q <= 1'b1;
            state_q   <= MUL_P;
          end
        end
        MUL_P: begin
          p_q     <= mbus.mult_p;
          state_q <= MUL_I;
        end
        MUL_I: begin
          i_q     <= mbus.mult_p;
          state_q <= MUL_D;
        end
        MUL_D: begin
          d_q     <= mbus.mult_p;
          state_q <= SUMA;
        end
        SUMA: begin
          u_q        <= sat(ext(p_q) + ext(i_q) + ext(d_q));
          u_valido_q <= 1'b1;
          e_prev_q   <= e_k_q;
          ocupado_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign u        = u_q;
  assign u_valido = u_valido_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_pid_secuenciador.sv
// Directed bench for pid_secuenciador with a saturating multiplier model.
module tb_pid_secuenciador;

  localparam int N   = 18;
  localparam int DIV = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                habilitar = 1'b1;
  logic signed [N-1:0] error = '0;
  logic signed [N-1:0] kp = '0;
  logic signed [N-1:0] ki = '0;
  logic signed [N-1:0] kd = '0;
  logic signed [N-1:0] u;
  logic                u_valido;
  logic                ocupado;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_strobe = 0;
  longint integ_m = 0;
  longint eprev_m = 0;

  pid_secuenciador_if #(.N(N)) bus ();

  pid_secuenciador #(.DIV_MUESTREO(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .habilitar (habilitar),
    .error     (error),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .mbus      (bus.master),
    .u         (u),
    .u_valido  (u_valido),
    .ocupado   (ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint sat_m(input longint x);
    if (x > 131071)  return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  assign bus.mult_p = N'(sat_m(longint'(bus.mult_a) * longint'(bus.mult_b)));

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_u", u, 0);
    chk("rst_valido", u_valido, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    integ_m = 0;
    eprev_m = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the next sequence and checks every stage of it.
  task automatic run_sample(input longint k_p, input longint k_i, input longint k_d,
                            input longint e, input longint exp_u,
                            input bit drop_en, input bit chk_per);
    longint diff_e, integ_e;
    bit found;
    kp = N'(k_p); ki = N'(k_i); kd = N'(k_d); error = N'(e);
    diff_e  = sat_m(e - eprev_m);
    integ_e = sat_m(integ_m + e);
    found = 1'b0;
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge clk);
      if (ocupado) begin found = 1'b1; break; end
    end
    if (!found) begin
      chk("tick_timeout", 0, 1);
      return;
    end
    chk("p_mult_a", bus.mult_a, k_p);
    chk("p_mult_b", bus.mult_b, e);
    if (drop_en) habilitar = 1'b0;
    @(negedge clk);
    chk("i_mult_a", bus.mult_a, k_i);
    chk("i_mult_b", bus.mult_b, integ_e);
    @(negedge clk);
    chk("d_mult_a", bus.mult_a, k_d);
    chk("d_mult_b", bus.mult_b, diff_e);
    @(negedge clk);
    chk("suma_mult", {bus.mult_a, bus.mult_b} == '0, 1);
    chk("suma_valido", u_valido, 0);
    chk("suma_ocupado", ocupado, 1);
    @(negedge clk);
    chk("strobe", u_valido, 1);
    chk("u", u, exp_u);
    chk("done_ocupado", ocupado, 0);
    if (chk_per) chk("period", cyc - last_strobe, DIV);
    last_strobe = cyc;
    @(negedge clk);
    chk("strobe_1cyc", u_valido, 0);
    chk("u_hold", u, exp_u);
    integ_m = integ_e;
    eprev_m = e;
  endtask

  typedef struct {
    bit     rst;
    longint kp, ki, kd, err, exp_u;
    bit     per;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int strobes;
    tbl[0]  = '{1, 2, 0, 0, 100, 200, 0};
    tbl[1]  = '{0, 2, 0, 0, 100, 200, 1};
    tbl[2]  = '{1, 0, 1, 0, 5, 5, 0};
    tbl[3]  = '{0, 0, 1, 0, 5, 10, 0};
    tbl[4]  = '{0, 0, 1, 0, 5, 15, 0};
    tbl[5]  = '{0, 0, 1, 0, -5, 10, 0};
    tbl[6]  = '{1, 0, 0, 1, 10, 10, 0};
    tbl[7]  = '{0, 0, 0, 1, 30, 20, 0};
    tbl[8]  = '{0, 0, 0, 1, 30, 0, 0};
    tbl[9]  = '{1, 1, 1, 0, 131071, 131071, 0};
    tbl[10] = '{0, 1, 1, 0, 131071, 131071, 0};
    tbl[11] = '{0, 1, 1, 0, -131072, -131072, 0};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      run_sample(tbl[i].kp, tbl[i].ki, tbl[i].kd, tbl[i].err, tbl[i].exp_u, 1'b0, tbl[i].per);
    end

    // Reset during MUL_I aborts the sequence and clears history.
    do_reset();
    run_sample(1, 0, 0, 50, 50, 1'b0, 1'b0);
    kp = 18'sd1; error = 18'sd9;
    begin
      bit found = 1'b0;
      for (int k = 0; k < 3 * DIV; k++) begin
        @(negedge clk);
        if (ocupado) begin found = 1'b1; break; end
      end
      chk("abort_seq_started", found, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_u", u, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_valido", u_valido, 0);
    integ_m = 0;
    eprev_m = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_valido) strobes++;
    end
    chk("abort_no_strobe", strobes, 0);
    run_sample(0, 0, 1, 7, 7, 1'b0, 1'b0);

    // habilitar dropped in MUL_P: sequence completes, then silence.
    run_sample(1, 0, 0, 3, 3, 1'b1, 1'b0);
    strobes = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge clk);
      if (u_valido || ocupado) strobes++;
    end
    chk("disabled_no_seq", strobes, 0);
    chk("disabled_u_hold", u, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
